// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for MIPS DIV/DIVU: one quotient bit per cycle, 32 ON cycles.
// HI gets the remainder and LO the quotient; ready pulses for one cycle in END.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] result_lo,
  output logic              ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  quo;        // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [DATA_W-1:0]  rem;
  logic [DATA_W-1:0]  dvs;
  logic [DATA_W-1:0]  orig;
  logic               neg_q, neg_r;

  logic               accept;
  logic [DATA_W-1:0]  op1_mag, op2_mag;
  logic [DATA_W:0]    shifted;
  logic               ge;
  logic [DATA_W-1:0]  rem_step, quo_step;
  logic [DATA_W-1:0]  q_fin, r_fin;

  assign accept = start && !annul;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = (opdata2 == '0) ? S_DIVZERO : S_ON;
      S_DIVZERO: state_nxt = annul ? S_IDLE : S_END;
      S_ON: begin
        if (annul)                               state_nxt = S_IDLE;
        else if (count == CNT_W'(DATA_W - 1))    state_nxt = S_END;
      end
      S_END:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    op1_mag  = (signed_div && opdata1[DATA_W-1]) ? ('0 - opdata1) : opdata1;
    op2_mag  = (signed_div && opdata2[DATA_W-1]) ? ('0 - opdata2) : opdata2;
    shifted  = {rem, quo[DATA_W-1]};
    ge       = shifted >= {1'b0, dvs};
    // When ge holds the difference is below the divisor, so it always fits DATA_W bits.
    rem_step = ge ? (shifted[DATA_W-1:0] - dvs) : shifted[DATA_W-1:0];
    quo_step = {quo[DATA_W-2:0], ge};
    q_fin    = neg_q ? ('0 - quo_step) : quo_step;
    r_fin    = neg_r ? ('0 - rem_step) : rem_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      orig      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == S_END);
      busy  <= (state_nxt == S_DIVZERO) || (state_nxt == S_ON);
      case (state)
        S_IDLE: begin
          if (accept) begin
            quo   <= op1_mag;
            dvs   <= op2_mag;
            rem   <= '0;
            count <= '0;
            orig  <= opdata1;
            neg_q <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_r <= signed_div && opdata1[DATA_W-1];
          end
        end
        S_ON: begin
          quo   <= quo_step;
          rem   <= rem_step;
          count <= count + 1'b1;
          if (state_nxt == S_END) begin
            result_lo <= q_fin;
            result_hi <= r_fin;
          end
        end
        S_DIVZERO: begin
          if (state_nxt == S_END) begin
            result_lo <= '1;
            result_hi <= orig;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model plus per-cycle compare of ready/busy/results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic [31:0] result_hi, result_lo;
  logic        ready, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: busy window, ready cycle, pending and visible results.
  int          busy_lo = 0;
  int          busy_hi = -1;
  int          rdy_at  = -1;
  logic [31:0] pq = '0, pr = '0;
  logic [31:0] exp_lo = '0, exp_hi = '0;

  div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .opdata1(opdata1), .opdata2(opdata2),
    .result_hi(result_hi), .result_lo(result_lo), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  always @(negedge clk) begin
    if (cyc == rdy_at) begin
      exp_lo = pq;
      exp_hi = pr;
    end
    check("ready", {31'd0, ready}, {31'd0, cyc == rdy_at});
    check("busy",  {31'd0, busy},  {31'd0, (cyc >= busy_lo) && (cyc <= busy_hi)});
    check("result_lo", result_lo, exp_lo);
    check("result_hi", result_hi, exp_hi);
  end

  // ev > 0: annul in ON cycle ev; ev < 0: async reset in ON cycle -ev; lq/lr are the literal results required afterwards.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int ev,
                        input logic [31:0] lq, input logic [31:0] lr);
    int t, lat;
    bit cut;
    cut = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
    t = cyc;
    model(s, a, b, pq, pr);
    lat = (b == 32'd0) ? 2 : 33;
    busy_lo = t + 1; busy_hi = t + lat - 1; rdy_at = t + lat;
    for (int k = 1; k <= lat && !cut; k++) begin
      @(posedge clk); #1;
      opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
      if (ev > 0 && k == ev) begin
        annul = 1'b1; start = 1'b0;
        busy_hi = cyc; rdy_at = -1;
        @(posedge clk); #1;
        annul = 1'b0;
        cut = 1'b1;
      end else if (ev < 0 && k == -ev) begin
        #2;
        rst = 1'b1; start = 1'b0;
        busy_hi = -1; rdy_at = -1; exp_lo = '0; exp_hi = '0;
        #1;
        check("rst_async_lo", result_lo, 32'd0);
        check("rst_async_hi", result_hi, 32'd0);
        check("rst_async_ready", {31'd0, ready}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cut = 1'b1;
      end
    end
    if (ev >= 0) begin
      check("lit_lo", result_lo, lq);
      check("lit_hi", result_hi, lr);
    end
    if (!cut) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    #1;
    check("reset_lo", result_lo, 32'd0);
    check("reset_hi", result_hi, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 32'd1);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 32'h8000_0000);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 32'hFFFF_FFFF, 32'd0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 0, 32'hFFFF_FFFF, 32'h1234_5678);
    do_div(1'b0, 32'd1000, 32'd3, 10, 32'hFFFF_FFFF, 32'h1234_5678);
    do_div(1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2);
    do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Simultaneous start and annul in IDLE must not launch a divide.
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);

    do_div(1'b1, 32'd1000, 32'hFFFF_FFFD, -5, 32'd0, 32'd0);
    do_div(1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit MIPS DIV/DIVU engine in the EX stage.
- Produces remainder (HI) and quotient (LO); these are the write data for the HI/LO register file. Its `ready` pulse gates that register's write enable.
- Restoring radix-2 algorithm, one quotient bit per cycle.
- Request/ready handshake with annul, so exceptions and flushes can kill an in-flight divide.

Parameters:
- DATA_W, 32, operand and result width. Only 32 is supported. The counter width is derived as clog2(DATA_W)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  divide request; sampled only in IDLE
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- annul  in  1  kill in-flight or requested divide (flush/exception)
- opdata1  in  DATA_W  dividend (rs)
- opdata2  in  DATA_W  divisor (rt)
- result_hi  out  DATA_W  remainder
- result_lo  out  DATA_W  quotient
- ready  out  1  one-cycle pulse; results valid
- busy  out  1  divide in progress

Behaviour:
- Reset (async, any state): state=IDLE; result_hi=0, result_lo=0, ready=0, busy=0; counter and internal registers cleared.
- States: IDLE, DIVZERO, ON, END. All outputs are registered.
- IDLE:
  - If start=1 and annul=0, latch opdata1, opdata2 and signed_div.
  - If the divisor is 0, go to DIVZERO; otherwise go to ON with count=0.
  - If signed, convert operands to magnitudes and record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - annul=1 in IDLE blocks acceptance.
- ON:
  - Each cycle: shift the partial remainder left by 1 and bring in the next dividend bit.
  - If partial remainder >= |divisor|, subtract and set the quotient bit to 1.
  - count increments each cycle; after the 32nd ON cycle go to END.
- DIVZERO: lasts 1 cycle, then go to END with quotient=32'hFFFFFFFF and remainder=original dividend (deterministic choice; MIPS leaves this UNPREDICTABLE).
- END:
  - On entry, result_lo and result_hi are loaded with sign-corrected values.
  - ready=1 for exactly this cycle; next state is IDLE unconditionally.
  - start is ignored in END.
- Latency:
  - start accepted in cycle t → ON occupies t+1..t+32 → ready=1 in t+33.
  - Divide by zero: ready=1 in t+2.
- busy=1 in DIVZERO and ON; 0 in IDLE and END.
- Upstream stall rule: stall = start & ~ready. Upstream deasserts start in the cycle after ready.
- result_hi/result_lo hold their value after END until the next END (or reset). They are not cleared on IDLE.
- annul=1 in DIVZERO, ON or END: go to IDLE at the next edge. If END is annulled, its ready pulse is still emitted in the current cycle, so the hazard unit must mask the HI/LO write in that case. Results registers are not updated by an annulled operation.
- Operand changes after acceptance are ignored.
- Signed arithmetic:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Unsigned: operands are used as-is; no sign correction.
- Simultaneous start and annul in IDLE: annul wins; stay IDLE.

Test Plan:
- Unsigned 100/7:
  - Stimulus: DIVU opdata1=100, opdata2=7, start in cycle t.
  - Required: busy=1 in t+1..t+32; ready=1 only in t+33; result_lo=14, result_hi=2.
- Signed -7/2:
  - Stimulus: DIV opdata1=0xFFFFFFF9, opdata2=2.
  - Required: result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF.
  - Repeat with 7/-2: result_lo=0xFFFFFFFD, result_hi=1.
- Overflow and unsigned corner:
  - DIV 0x80000000/0xFFFFFFFF: result_lo=0x80000000, result_hi=0.
  - DIVU with the same operands: result_lo=0, result_hi=0x80000000.
- Divide by zero:
  - Stimulus: DIVU opdata1=0x12345678, opdata2=0, start in t.
  - Required: ready in t+2, result_lo=0xFFFFFFFF, result_hi=0x12345678, busy=1 only in t+1.
- Annul during divide:
  - Stimulus: annul in the 10th ON cycle.
  - Required: IDLE next cycle, no ready pulse, results unchanged from the prior op. A new start two cycles later completes correctly (100/7).
- Async reset mid-divide:
  - Stimulus: rst pulsed between clock edges during ON.
  - Required: all outputs 0 immediately, without waiting for an edge. After release, start produces ready in t+33 with correct results.
